// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller.
// Size codes, FSM states, the captured-request payload and per-size lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
  } req_t;

  // Byte lanes touched by an access, relative to its (aligned) base address.
  function automatic logic [3:0] size_be(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_be = 4'b0001;
      SZ_HALF: size_be = 4'b0011;
      SZ_WORD: size_be = 4'b1111;
      default: size_be = 4'b0000;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_HALF: align_mask = 2'b01;
      SZ_WORD: align_mask = 2'b11;
      default: align_mask = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage: synchronous 4-lane byte-enable write, combinational 4-byte read.
// Lane k maps to address addr_i+k, wrapping modulo the depth.
module dmem_byte_array #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (be_i[k]) begin
        mem_q[addr_i + ADDR_W'(k)] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < 4; k++) begin
      rdata_o[8*k +: 8] = mem_q[addr_i + ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: valid/ready request, LATENCY busy cycles, one-cycle response.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses error instead of being force-aligned.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              accept;
  logic              last_busy;
  logic              err_c;
  logic [ADDR_W-1:0] eff_addr;
  logic [3:0]        be_c;
  logic [31:0]       rd_word;
  logic [31:0]       load_c;
  logic              unused_addr_hi;

  // Address bits above the decoded range are intentionally dropped (wrap).
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign req_ready = !rst && (state_q == IDLE || state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign last_busy = (state_q == BUSY) && (cnt_q == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = |(addr_q[1:0] & align_mask(req_q.size));
  assign eff_addr   = addr_q;
  assign err_c      = (req_q.size == SZ_ILLEGAL) || misalign_c;
`else
  assign eff_addr   = addr_q & ~ADDR_W'(align_mask(req_q.size));
  assign err_c      = (req_q.size == SZ_ILLEGAL);
`endif

  // Stores commit only on the BUSY->RESP edge, and never under reset or error.
  assign be_c = (last_busy && req_q.write && !err_c && !rst) ? size_be(req_q.size) : 4'b0000;

  dmem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .addr_i  (eff_addr),
    .be_i    (be_c),
    .wdata_i (req_q.wdata),
    .rdata_o (rd_word)
  );

  // Lane select is already done by the array base address; only extension remains.
  always_comb begin
    case (req_q.size)
      SZ_BYTE: load_c = {{24{req_q.sext & rd_word[7]}}, rd_word[7:0]};
      SZ_HALF: load_c = {{16{req_q.sext & rd_word[15]}}, rd_word[15:0]};
      default: load_c = rd_word;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d     = BUSY;
          cnt_d       = CNT_W'(LATENCY - 1);
          req_d.write = req_write;
          req_d.size  = req_size;
          req_d.sext  = req_signed;
          req_d.wdata = req_wdata;
          addr_d      = req_addr[ADDR_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_c;
          resp_rdata_d = (err_c || req_q.write) ? 32'h0 : load_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (ADDR_W=8, LATENCY=2) against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [DEPTH];

  dmem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, accesses computed arithmetically.
  function automatic void model(input bit wr, input logic [1:0] sz, input bit sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output bit err);
    int unsigned base = a % DEPTH;
    int unsigned nb;
    longint unsigned val = 0;
    rd  = 32'h0;
    err = 1'b0;
    if (sz == 2'b11) begin
      err = 1'b1;
      return;
    end
    nb = 1 << sz;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (base % nb != 0) begin
      err = 1'b1;
      return;
    end
`else
    base = base - (base % nb);
`endif
    if (wr) begin
      for (int k = 0; k < int'(nb); k++) model_mem[(base + k) % DEPTH] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < int'(nb); k++) val = val + (longint'(model_mem[(base + k) % DEPTH]) << (8*k));
      if (sg && nb < 4 && val >= (longint'(1) << (8*nb - 1))) val = val + 64'hFFFF_FFFF - ((longint'(1) << (8*nb)) - 1);
      rd = 32'(val);
    end
  endfunction

  // Issue one request from a negedge; ends at the negedge of the response cycle.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                        input string tag);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      @(negedge clk);
      check({tag, "_busy_valid"}, 32'(resp_valid), 32'h0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(resp_valid), 32'h1);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
  endtask

  task automatic op(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                    input logic [31:0] wd, input string tag);
    logic [31:0] rd;
    bit e;
    model(wr, sz, sg, a, wd, rd, e);
    do_req(wr, sz, sg, a, wd, rd, e, tag);
  endtask

  task automatic op_const(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                          input string tag);
    logic [31:0] rd;
    bit e;
    model(wr, sz, sg, a, wd, rd, e);
    do_req(wr, sz, sg, a, wd, exp_rd, exp_err, tag);
  endtask

  initial begin
    logic [31:0] rd;
    bit          e;
    logic [31:0] exp_a, exp_b;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);

    for (int w = 0; w < int'(DEPTH / 4); w++) op(1'b1, 2'b10, 1'b0, 32'(4*w), $urandom, "init");

    op_const(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_word");
    op_const(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_word");
    op_const(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "ld_bs");
    op_const(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0, "ld_bu");
    op_const(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "ld_hs");
    op_const(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, "ld_hu");
    op_const(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, 32'h0, 1'b0, "st_byte");
    op_const(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "ld_after_sb");
    op_const(1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 32'hDEAD55EF, 1'b0, "ld_wrap");
`ifdef DMEM_MISALIGN_TRAP_EN
    op_const(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "ld_h_mis");
    op_const(1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 32'h0, 1'b1, "st_w_mis");
`else
    op_const(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h000055EF, 1'b0, "ld_h_mis");
    op_const(1'b1, 2'b10, 1'b0, 32'h12, 32'hDEAD55EF, 32'h0, 1'b0, "st_w_mis");
`endif
    op_const(1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304, 32'h0, 1'b1, "st_illegal");
    op_const(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 32'h0, 1'b1, "ld_illegal");
    op_const(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "ld_unchanged");

    // Back-to-back: valid held high, second load accepted in the RESP cycle.
    model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, exp_a, e);
    model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, exp_b, e);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h40;
    @(posedge clk);
    #1 req_addr = 32'h10;
    @(negedge clk); check("b2b_t1_valid", 32'(resp_valid), 32'h0);
    check("b2b_t1_ready", 32'(req_ready), 32'h0);
    @(negedge clk); check("b2b_t2_valid", 32'(resp_valid), 32'h0);
    @(negedge clk); check("b2b_t3_valid", 32'(resp_valid), 32'h1);
    check("b2b_t3_rdata", resp_rdata, exp_a);
    check("b2b_t3_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); check("b2b_t4_valid", 32'(resp_valid), 32'h0);
    @(negedge clk); check("b2b_t5_valid", 32'(resp_valid), 32'h0);
    @(negedge clk); check("b2b_t6_valid", 32'(resp_valid), 32'h1);
    check("b2b_t6_rdata", resp_rdata, exp_b);
    @(negedge clk); check("b2b_t7_valid", 32'(resp_valid), 32'h0);

    // Reset during BUSY discards the pending store and its response.
    model(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, exp_a, e);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("abort_valid", 32'(resp_valid), 32'h0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, exp_a, 1'b0, "ld_after_abort");

    // Reset coinciding with a handshake: request must not be accepted.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("rst_hs_valid", 32'(resp_valid), 32'h0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, exp_a, 1'b0, "ld_after_rst_hs");

    for (int i = 0; i < 200; i++) begin
      logic [1:0] sz = 2'($urandom_range(0, 3));
      op(1'($urandom), sz, 1'($urandom), $urandom, $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, multi-cycle data-memory controller for the processor's load/store path. It replaces a fixed single-cycle word memory with a valid/ready request port, configurable depth and access latency, and byte, half and word accesses with sign or zero extension. It sits between the processor's ALU address/store-data outputs and the register-file write-back mux. It holds one request in flight at a time.

## Interface
- ADDR_W, 8: byte-address bits actually decoded; depth is 2^ADDR_W bytes; legal range 2..16.
- LATENCY, 2: number of BUSY wait cycles between acceptance and response; legal value is 1 or more.
- clk  input  1  clock; every state element updates on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request; high in IDLE or RESP, low while rst is high.
- req_write  input  1  1 selects store, 0 selects load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  input  32  byte address; bits above ADDR_W-1 are ignored, so addresses wrap modulo the depth.
- req_wdata  input  32  store data, right-aligned (the byte is in [7:0], the half in [15:0]).
- resp_valid  output  1  one-cycle response strobe; there is no back-pressure on the response.
- resp_rdata  output  32  load result; 0 for stores and for errors.
- resp_err  output  1  access error flag, qualified by resp_valid.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: counting down the access latency.
  - RESP: presenting the response.
- Handshake: a request is accepted when req_valid && req_ready are both high at a rising edge. All req_* fields are captured into registers at that edge and may change afterwards.
- Transitions:
  - IDLE or RESP, on accept: go to BUSY and load the wait counter with LATENCY-1.
  - BUSY with counter ≠ 0: decrement the counter.
  - BUSY with counter == 0: go to RESP. The memory operation executes at this edge, and resp_* are registered at the same edge.
  - RESP with no accept: go to IDLE.
- Byte ordering is little-endian: byte k of a word lives at address a+k.
- Loads: select the addressed byte or half, then sign- or zero-extend it to 32 bits according to the captured req_signed.
- Stores: write only the lanes covered by the access size. All other bytes are unchanged.
- Illegal size (11): resp_err=1, resp_rdata=0, no write. Latency is unchanged.
- A load issued after a store observes the store's data, because the store commits at its BUSY→RESP edge.
- Memory contents are not cleared by reset. Their power-up value is undefined.

## Timing
- Reset values: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0. req_ready is 0 during rst and 1 in the first cycle after rst deasserts.
- Accept in cycle T: BUSY occupies cycles T+1..T+LATENCY, and resp_valid is high in cycle T+LATENCY+1 only.
- Back-to-back: a request may be accepted in the RESP cycle, giving sustained throughput of one access per LATENCY+1 cycles.
- Reset mid-operation: rst high in BUSY or RESP forces IDLE at that edge. The pending store is discarded (no write), and no response is produced for the aborted request.
- rst together with a handshake: reset wins and the request is not accepted.

## Configuration
- DMEM_MISALIGN_TRAP_EN, defined: a half access at an odd address, or a word access whose address is not a multiple of 4, responds with resp_err=1 and resp_rdata=0. No write occurs and the latency is unchanged.
- DMEM_MISALIGN_TRAP_EN, undefined: the low address bits are cleared to alignment (bit 0 for half, bits 1:0 for word). The access then proceeds normally and resp_err is asserted only for illegal size.

## Structure
- Package dmem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL;
  - the state enum (IDLE, BUSY, RESP).
- One sub-module, dmem_byte_array: a 2^ADDR_W × 8 synchronous-write array with a 4-lane byte-enable write port and a combinational 4-byte read.
- Lane steering, extension and the FSM stay in dmem_ctrl.

## Test plan
All scenarios use ADDR_W=8, LATENCY=2.
- Store word 0xDEADBEEF at 0x10 (accepted in cycle T), then load word 0x10 -> the store's resp_valid is high in T+3 only with err=0; the load returns rdata 0xDEADBEEF.
- Extension from the same word: load byte signed at 0x13 -> 0xFFFFFFDE; byte unsigned at 0x13 -> 0x000000DE; half signed at 0x10 -> 0xFFFFBEEF; half unsigned at 0x12 -> 0x0000DEAD.
- Store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF. Load word at 0x110 -> the same value (address wrap).
- Half load at 0x11:
  - with the macro defined -> err=1, rdata=0;
  - without it -> rdata as for 0x10;
  - size=11 -> err=1 and memory unchanged.
- req_valid held high with back-to-back loads -> a second request is accepted in the RESP cycle and resp_valid pulses every 3 cycles.
- Store 0x12345678 to 0x20 with rst pulsed in its first BUSY cycle -> no resp_valid. A following load at 0x20 returns the prior contents.
